fifo_rd_stream: RTL

//  Read-side drain stage placed directly downstream of sync_fifo.
//  - Drives the FIFO's rd_en and captures its registered rdata one cycle later.
//  - Re-presents the words as a valid/ready stream, buffered in a 2-entry skid buffer.
//  - Counts delivered words and flags protocol faults reported by the FIFO.

---
 rtl/fifo_rd_stream_pkg.sv | 10 +
 rtl/fifo_rd_stream_if.sv | 12 +
 rtl/fifo_rd_stream_skid.sv | 30 +++
 rtl/fifo_rd_stream.sv | 43 ++++
 4 files changed

// File: rtl/fifo_rd_stream_pkg.sv
// fifo_rd_stream_pkg: shared widths, skid depth and the read-credit rule
package fifo_rd_stream_pkg;
  localparam int DEF_WIDTH = 4;
  localparam int DEF_CNT_W = 16;
  localparam int SKID_DEPTH = 2;
  typedef logic [$clog2(SKID_DEPTH + 1)-1:0] cnt_t;
  function automatic logic has_credit(cnt_t count, logic inflight, logic pop);
    return ({1'b0, count} + 3'(inflight) - 3'(pop)) < 3'(SKID_DEPTH);
  endfunction
endpackage

// File: rtl/fifo_rd_stream_if.sv
// fifo_rd_stream_if: FIFO read port plus valid/ready output stream
interface fifo_rd_stream_if #(parameter int WIDTH = fifo_rd_stream_pkg::DEF_WIDTH);
  logic empty;
  logic error;
  logic rd_en;
  logic [WIDTH-1:0] rdata;
  logic valid;
  logic ready;
  logic [WIDTH-1:0] data;
  modport master (input empty, error, rdata, ready, output rd_en, valid, data);
  modport slave (output empty, error, rdata, ready, input rd_en, valid, data);
endinterface

// File: rtl/fifo_rd_stream_skid.sv
// fifo_rd_stream_skid: 2-entry in-order buffer, head registered on the output
module fifo_rd_stream_skid
  import fifo_rd_stream_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] head,
  output logic             valid,
  output cnt_t             count
);
  logic [WIDTH-1:0] tail;
  assign valid = count != '0;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (pop || (push && count == '0)) head <= (pop && count == 2'd2) ? tail : din;
      if (push && (pop ? count == 2'd2 : count == 2'd1)) tail <= din;
      count <= count + cnt_t'(push) - cnt_t'(pop);
    end
  end
  a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n) !(push && count == 2'd2));
endmodule

// File: rtl/fifo_rd_stream.sv
// fifo_rd_stream: drains sync_fifo into a valid/ready stream
// with credit-based reads, a delivered-word counter and a sticky fault flag.
module fifo_rd_stream
  import fifo_rd_stream_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int CNT_W = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  fifo_rd_stream_if.master bus,
  output logic [CNT_W-1:0] words,
  output logic             err
);
  logic inflight;
  logic pop;
  cnt_t count;
  assign pop = bus.valid & bus.ready;
  // a pop this cycle frees a slot, so ready feeds straight into rd_en
  assign bus.rd_en = rst_n & en & ~bus.empty & has_credit(count, inflight, pop);
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      inflight <= 1'b0;
      words    <= '0;
      err      <= 1'b0;
    end else begin
      inflight <= bus.rd_en;
      words    <= words + CNT_W'(pop);
      err      <= err | (inflight & bus.error);
    end
  end
  fifo_rd_stream_skid #(.WIDTH(WIDTH)) u_skid (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (inflight),
    .pop   (pop),
    .din   (bus.rdata),
    .head  (bus.data),
    .valid (bus.valid),
    .count (count)
  );
endmodule
